instmem_pipe: RTL and testbench
===============================

# instmem_pipe

Parametrised synchronous instruction memory for the multicycle/pipelined CPU generation: a RAM-backed instruction store with a valid/ready fetch handshake and a programmable number of wait states. It also has a write-only load port for filling the program at boot or from a debug host, and reports misaligned and out-of-range fetches. It replaces the single-cycle combinational instruction ROM and sits between the fetch stage (PC side) and the program loader.

## Interface
- DATA_W, 32: instruction width in bits.
- DEPTH, 32: number of words; power of two, ≥ 2; IDX_W = log2(DEPTH).
- WAIT_CYCLES, 0: extra cycles between accept and response, 0–15.
- NOP_WORD, 32'h00000000: value returned on an erroneous fetch.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request valid.
- f_addr  in  32  byte address of the instruction.
- f_ready  out  1  request accepted when f_req & f_ready.
- r_valid  out  1  response valid.
- r_ready  in  1  consumer takes response when r_valid & r_ready.
- r_data  out  DATA_W  fetched instruction.
- r_err  out  1  fetch was misaligned or out of range.
- ld_we  in  1  load-port write strobe.
- ld_idx  in  IDX_W  word index to write.
- ld_data  in  DATA_W  word to write.

## Operation
- Word index = f_addr[IDX_W+1:2].
- Error when f_addr[1:0] != 0 or f_addr[31:IDX_W+2] != 0. On error: r_data = NOP_WORD, r_err = 1, and the array is not read.
- FSM states:
  - IDLE: f_ready = 1. On accept, latch the index and error flag, load wait counter = WAIT_CYCLES, then go to WAIT if WAIT_CYCLES > 0, else to RESP.
  - WAIT: counter decrements once per cycle. When it reaches 1, go to RESP.
  - RESP: r_valid = 1, r_data and r_err stable.
    - On r_ready, with no new accept: go to IDLE.
    - f_ready = r_ready in RESP, so a new request may be accepted in the same cycle the response is consumed. It then follows the IDLE accept rules.
- r_data register is loaded from mem[latched index] on the edge entering RESP.
- One request outstanding at most. No request is accepted in WAIT.
- Load port: on ld_we, mem[ld_idx] <= ld_data at the clock edge, in any state. Writes are never blocked.
- Read/write collision: if ld_we targets the latched index on the edge entering RESP, r_data gets the old word (read-before-write). The new word is visible to later fetches.
- Array contents are not affected by rst. Only control state is reset.

## Timing
- Reset values: state = IDLE, f_ready = 1, r_valid = 0, r_data = 0, r_err = 0, wait counter = 0.
- rst asserted mid-transaction aborts the outstanding fetch; no response is produced. A load write on the edge where rst is asserted is dropped.
- Latency from accept edge to r_valid high = 1 + WAIT_CYCLES cycles.
- Throughput with WAIT_CYCLES = 0 and r_ready held high: one instruction per cycle, with f_ready continuously 1.
- Throughput with WAIT_CYCLES = N: one instruction per N + 1 cycles at best.
- Backpressure: while r_valid & !r_ready, r_data/r_err hold and f_ready = 0.
- f_addr is sampled only at accept. Changes outside the accept cycle have no effect.

## Test plan
1. Load then read: load mem[0..3] = 3c010000, 34240050, 20050004, 0c000018. With WAIT_CYCLES = 0 and r_ready = 1, issue fetches at addresses 0, 4, 8, 0c back-to-back -> r_valid high on 4 consecutive cycles starting 1 cycle after the first accept, carrying those words in order, r_err = 0.
2. Wait states: WAIT_CYCLES = 3, fetch address 4 (word 34240050) -> r_valid rises exactly 4 cycles after accept. f_ready = 0 for those cycles and stays 0 until r_ready.
3. Errors with DEPTH = 32:
   - Fetch 0x06 -> r_err = 1, r_data = 00000000.
   - Fetch 0x80 -> r_err = 1, r_data = 00000000.
   - Fetch 0x7c -> r_err = 0 and the word at index 31.
4. Backpressure: hold r_ready = 0 for 5 cycles after r_valid -> r_data stable, f_ready = 0. On r_ready = 1 with f_req = 1, the next request is accepted in that same cycle.
5. Collision: mem[5] = 8c890000. Accept a fetch of 0x14, and in the cycle before the response edge write ld_idx = 5, ld_data = 01244022 -> response shows 8c890000. The next fetch of 0x14 returns 01244022.
6. Reset: assert rst during WAIT (WAIT_CYCLES = 3) -> r_valid never rises and f_ready = 1 immediately. A previously loaded word at index 2 (20050004) is still read correctly after reset.

Source files
------------

// File: rtl/instmem_pipe.sv
// RAM-backed instruction store with a valid/ready fetch handshake, programmable wait states,
// a write-only load port, and misaligned/out-of-range fetch reporting.
module instmem_pipe #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 32,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = '0,
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  output logic              f_ready_o,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_err_o,
  input  logic              ld_we_i,
  input  logic [IDX_W-1:0]  ld_idx_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  // state  | meaning
  // S_IDLE | ready for a fetch
  // S_WAIT | counting down wait states for the accepted fetch
  // S_RESP | response presented, waiting for r_ready_i
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_err_q, r_err_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  f_idx;
  logic              f_err;
  logic              accept;
  logic              load_resp;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_err;

  assign f_idx = f_addr_i[IDX_W+1:2];
  assign f_err = (f_addr_i[1:0] != 2'b00) || ((f_addr_i >> (IDX_W + 2)) != 32'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    f_ready_o = 1'b0;
    r_valid_o = 1'b0;
    load_resp = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: f_ready_o = 1'b1;
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end
      end
      S_RESP: begin
        r_valid_o = 1'b1;
        f_ready_o = r_ready_i;
        if (r_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept = f_req_i & f_ready_o;
    if (accept) begin
      idx_d = f_idx;
      err_d = f_err;
      cnt_d = 4'(WAIT_CYCLES);
      if (WAIT_CYCLES > 0) begin
        state_d = S_WAIT;
      end else begin
        state_d   = S_RESP;
        load_resp = 1'b1;
      end
    end
  end

  // With zero wait states the response edge is the accept edge, so read the live index.
  always_comb begin
    rd_idx   = (state_q == S_WAIT) ? idx_q : f_idx;
    rd_err   = (state_q == S_WAIT) ? err_q : f_err;
    r_data_d = r_data_q;
    r_err_d  = r_err_q;
    if (load_resp) begin
      r_err_d  = rd_err;
      r_data_d = rd_err ? NOP_WORD : mem[rd_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      r_data_q <= '0;
      r_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      r_data_q <= r_data_d;
      r_err_q  <= r_err_d;
    end
  end

  // Array is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (ld_we_i && !rst_i) mem[ld_idx_i] <= ld_data_i;
  end

  assign r_data_o = r_data_q;
  assign r_err_o  = r_err_q;

endmodule

// File: tb/tb_instmem_pipe.sv
// Bench for instmem_pipe: one instance with no wait states, one with three, sharing
// clock, reset and load port; a transaction-level model predicts every response.
module tb_instmem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, r_ready, ld_we;
  logic [31:0] f_addr, ld_data;
  logic [4:0]  ld_idx;
  int          sel;

  logic        f_req0, f_ready0, r_valid0, r_err0;
  logic        f_req3, f_ready3, r_valid3, r_err3;
  logic [31:0] r_data0, r_data3;
  logic        f_ready_m, r_valid_m, r_err_m;
  logic [31:0] r_data_m;

  int total = 0;
  int bad   = 0;
  logic [31:0] mm [32];

  assign f_req0    = f_req && (sel == 0);
  assign f_req3    = f_req && (sel == 3);
  assign f_ready_m = (sel == 3) ? f_ready3 : f_ready0;
  assign r_valid_m = (sel == 3) ? r_valid3 : r_valid0;
  assign r_data_m  = (sel == 3) ? r_data3  : r_data0;
  assign r_err_m   = (sel == 3) ? r_err3   : r_err0;

  instmem_pipe #(.DATA_W(32), .DEPTH(32), .WAIT_CYCLES(0), .NOP_WORD(32'h0)) dut0 (
    .clk_i(clk), .rst_i(rst), .f_req_i(f_req0), .f_addr_i(f_addr), .f_ready_o(f_ready0),
    .r_valid_o(r_valid0), .r_ready_i(r_ready), .r_data_o(r_data0), .r_err_o(r_err0),
    .ld_we_i(ld_we), .ld_idx_i(ld_idx), .ld_data_i(ld_data));

  instmem_pipe #(.DATA_W(32), .DEPTH(32), .WAIT_CYCLES(3), .NOP_WORD(32'h0)) dut3 (
    .clk_i(clk), .rst_i(rst), .f_req_i(f_req3), .f_addr_i(f_addr), .f_ready_o(f_ready3),
    .r_valid_o(r_valid3), .r_ready_i(r_ready), .r_data_o(r_data3), .r_err_o(r_err3),
    .ld_we_i(ld_we), .ld_idx_i(ld_idx), .ld_data_i(ld_data));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected {err, data} of a fetch from the architectural rules.
  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'd128) return {1'b1, 32'h0};
    return {1'b0, mm[a / 4]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 31) * 4);
      2:       return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      default: return 32'h80 + ($urandom % 32'h7fff_ff80);
    endcase
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = idx[4:0]; ld_data = d;
    step;
    ld_we = 1'b0;
    mm[idx] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    total++; if (f_ready0 !== 1'b1 || f_ready3 !== 1'b1) begin bad++; $display("FAIL reset_f_ready: got %b/%b want 1/1", f_ready0, f_ready3); end
    total++; if (r_valid0 !== 1'b0 || r_valid3 !== 1'b0) begin bad++; $display("FAIL reset_r_valid: got %b/%b want 0/0", r_valid0, r_valid3); end
    total++; if (r_data0 !== 32'h0 || r_data3 !== 32'h0) begin bad++; $display("FAIL reset_r_data: got %h/%h want 0", r_data0, r_data3); end
    total++; if (r_err0 !== 1'b0 || r_err3 !== 1'b0) begin bad++; $display("FAIL reset_r_err: got %b/%b want 0/0", r_err0, r_err3); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_load_read;
    logic [31:0] prog [4] = '{32'h3c010000, 32'h34240050, 32'h20050004, 32'h0c000018};
    for (int i = 0; i < 32; i++) load(i, $urandom);
    for (int i = 0; i < 4; i++) load(i, prog[i]);
    sel = 0; r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_req = 1'b1; f_addr = 32'(i * 4);
      #1;
      total++; if (f_ready_m !== 1'b1) begin bad++; $display("FAIL b2b_f_ready[%0d]: got %b want 1", i, f_ready_m); end
      step;
      total++; if (r_valid_m !== 1'b1 || r_data_m !== prog[i] || r_err_m !== 1'b0)
        begin bad++; $display("FAIL b2b_resp[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=0", i, r_valid_m, r_data_m, r_err_m, prog[i]); end
    end
    f_req = 1'b0;
    step;
    total++; if (r_valid_m !== 1'b0) begin bad++; $display("FAIL b2b_drain: got r_valid=%b want 0", r_valid_m); end
  endtask

  task automatic test_wait_states;
    sel = 3; r_ready = 1'b0; f_req = 1'b1; f_addr = 32'h4;
    #1;
    total++; if (f_ready_m !== 1'b1) begin bad++; $display("FAIL wait_accept_ready: got %b want 1", f_ready_m); end
    step;
    f_addr = 32'h8;
    for (int k = 1; k <= 3; k++) begin
      total++; if (r_valid_m !== 1'b0 || f_ready_m !== 1'b0)
        begin bad++; $display("FAIL wait_cycle[%0d]: got v=%b rdy=%b want v=0 rdy=0", k, r_valid_m, f_ready_m); end
      step;
    end
    total++; if (r_valid_m !== 1'b1 || r_data_m !== 32'h34240050 || r_err_m !== 1'b0)
      begin bad++; $display("FAIL wait_resp: got v=%b d=%h e=%b want v=1 d=34240050 e=0", r_valid_m, r_data_m, r_err_m); end
    total++; if (f_ready_m !== 1'b0) begin bad++; $display("FAIL wait_resp_ready: got %b want 0", f_ready_m); end
    step;
    total++; if (r_valid_m !== 1'b1 || f_ready_m !== 1'b0)
      begin bad++; $display("FAIL wait_hold: got v=%b rdy=%b want v=1 rdy=0", r_valid_m, f_ready_m); end
    f_req = 1'b0; r_ready = 1'b1;
    #1;
    total++; if (f_ready_m !== 1'b1) begin bad++; $display("FAIL wait_release_ready: got %b want 1", f_ready_m); end
    step;
    total++; if (r_valid_m !== 1'b0) begin bad++; $display("FAIL wait_done: got r_valid=%b want 0", r_valid_m); end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [3] = '{32'h06, 32'h80, 32'h7c};
    logic [32:0] exp;
    load(31, $urandom);
    sel = 0; r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model_fetch(addrs[i]);
      f_req = 1'b1; f_addr = addrs[i];
      step;
      f_req = 1'b0;
      total++; if (r_valid_m !== 1'b1 || r_err_m !== exp[32] || r_data_m !== exp[31:0])
        begin bad++; $display("FAIL err_fetch[%h]: got v=%b e=%b d=%h want v=1 e=%b d=%h", addrs[i], r_valid_m, r_err_m, r_data_m, exp[32], exp[31:0]); end
      step;
    end
  endtask

  task automatic test_backpressure;
    sel = 0; r_ready = 1'b0; f_req = 1'b1; f_addr = 32'h8;
    step;
    f_addr = 32'hc;
    for (int k = 0; k < 5; k++) begin
      total++; if (r_valid_m !== 1'b1 || r_data_m !== mm[2] || r_err_m !== 1'b0 || f_ready_m !== 1'b0)
        begin bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=0 rdy=0", k, r_valid_m, r_data_m, r_err_m, f_ready_m, mm[2]); end
      step;
    end
    r_ready = 1'b1;
    #1;
    total++; if (f_ready_m !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", f_ready_m); end
    step;
    f_req = 1'b0;
    total++; if (r_valid_m !== 1'b1 || r_data_m !== mm[3])
      begin bad++; $display("FAIL bp_next: got v=%b d=%h want v=1 d=%h", r_valid_m, r_data_m, mm[3]); end
    step;
    total++; if (r_valid_m !== 1'b0) begin bad++; $display("FAIL bp_drain: got r_valid=%b want 0", r_valid_m); end
  endtask

  task automatic test_collision;
    logic [31:0] old_w;
    load(5, 32'h8c890000);
    sel = 3; r_ready = 1'b1; f_req = 1'b1; f_addr = 32'h14;
    step;
    f_req = 1'b0;
    step;
    step;
    old_w = mm[5];
    ld_we = 1'b1; ld_idx = 5'd5; ld_data = 32'h01244022;
    step;
    ld_we = 1'b0; mm[5] = 32'h01244022;
    total++; if (r_valid_m !== 1'b1 || r_data_m !== old_w)
      begin bad++; $display("FAIL coll_old: got v=%b d=%h want v=1 d=%h", r_valid_m, r_data_m, old_w); end
    step;
    f_req = 1'b1;
    step;
    f_req = 1'b0;
    repeat (3) step;
    total++; if (r_valid_m !== 1'b1 || r_data_m !== mm[5])
      begin bad++; $display("FAIL coll_new: got v=%b d=%h want v=1 d=%h", r_valid_m, r_data_m, mm[5]); end
    step;
    // Zero-wait instance: write lands on the accept edge itself.
    sel = 0;
    old_w = mm[5];
    f_req = 1'b1; f_addr = 32'h14;
    ld_we = 1'b1; ld_idx = 5'd5; ld_data = $urandom;
    step;
    f_req = 1'b0; ld_we = 1'b0; mm[5] = ld_data;
    total++; if (r_valid_m !== 1'b1 || r_data_m !== old_w)
      begin bad++; $display("FAIL coll0_old: got v=%b d=%h want v=1 d=%h", r_valid_m, r_data_m, old_w); end
    step;
  endtask

  task automatic test_random(input int w);
    bit          outstanding = 1'b0;
    bit          exp_valid, exp_ready;
    int          ready_at = 0;
    logic [32:0] exp = '0;
    sel = w;
    for (int c = 0; c < 400; c++) begin
      exp_valid = outstanding && (c >= ready_at);
      total++; if (r_valid_m !== exp_valid) begin bad++; $display("FAIL rnd%0d_valid[%0d]: got %b want %b", w, c, r_valid_m, exp_valid); end
      if (exp_valid) begin
        total++; if (r_data_m !== exp[31:0] || r_err_m !== exp[32])
          begin bad++; $display("FAIL rnd%0d_data[%0d]: got d=%h e=%b want d=%h e=%b", w, c, r_data_m, r_err_m, exp[31:0], exp[32]); end
      end
      r_ready = ($urandom_range(0, 2) != 0);
      f_req   = ($urandom_range(0, 3) != 0);
      f_addr  = rand_addr();
      #1;
      exp_ready = !outstanding || (exp_valid && r_ready);
      total++; if (f_ready_m !== exp_ready) begin bad++; $display("FAIL rnd%0d_ready[%0d]: got %b want %b", w, c, f_ready_m, exp_ready); end
      if (exp_valid && r_ready) outstanding = 1'b0;
      if (f_req && exp_ready) begin
        outstanding = 1'b1;
        ready_at    = c + 1 + w;
        exp         = model_fetch(f_addr);
      end
      step;
    end
    f_req = 1'b0; r_ready = 1'b1;
    repeat (w + 2) step;
  endtask

  task automatic test_reset_mid;
    int n;
    sel = 3; r_ready = 1'b1; f_req = 1'b1; f_addr = 32'h8;
    step;
    f_req = 1'b0;
    step;
    rst = 1'b1; ld_we = 1'b1; ld_idx = 5'd2; ld_data = 32'hdeadbeef;
    #1;
    total++; if (f_ready_m !== 1'b1 || r_valid_m !== 1'b0)
      begin bad++; $display("FAIL rstmid_now: got rdy=%b v=%b want rdy=1 v=0", f_ready_m, r_valid_m); end
    step;
    ld_we = 1'b0; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++; if (r_valid_m !== 1'b0) begin bad++; $display("FAIL rstmid_no_resp[%0d]: got r_valid=%b want 0", k, r_valid_m); end
      step;
    end
    f_req = 1'b1; f_addr = 32'h8;
    step;
    f_req = 1'b0;
    n = 0;
    while (r_valid_m !== 1'b1 && n < 10) begin step; n++; end
    total++; if (n != 3) begin bad++; $display("FAIL rstmid_latency: got %0d extra cycles want 3", n); end
    total++; if (r_valid_m !== 1'b1 || r_data_m !== mm[2] || r_data_m !== 32'h20050004)
      begin bad++; $display("FAIL rstmid_data: got v=%b d=%h want v=1 d=20050004", r_valid_m, r_data_m); end
    step;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; r_ready = 1'b0; ld_we = 1'b0;
    f_addr = '0; ld_idx = '0; ld_data = '0; sel = 0;
    test_reset;
    test_load_read;
    test_wait_states;
    test_errors;
    test_backpressure;
    test_collision;
    test_random(0);
    test_random(3);
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
